// File: rtl/demux_pkg.sv
// ============================================================================
// Module      : demux_pkg
// Description : Shared constants and state encoding for the 4-way dispatcher.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package demux_pkg;

    localparam int   NUM_CH     = 4;
    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_pick4.sv
// ============================================================================
// Module      : rr_pick4
// Description : Picks the first requesting channel starting at a rotating
//               pointer; purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick4
    import demux_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] start,
    output logic [1:0] idx,
    output logic       found
);

    logic [1:0] w_pos;

    // Scan from the farthest candidate back to start so the nearest one wins.
    always_comb begin
        idx   = 2'd0;
        found = 1'b0;
        w_pos = 2'd0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            w_pos = start + 2'(k);
            if (req[w_pos]) begin
                idx   = w_pos;
                found = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/demux_rr_dispatcher_x4.sv
// ============================================================================
// Module      : demux_rr_dispatcher_x4
// Description : One-entry holding stage that dispatches a valid/ready stream
//               to four channels (round-robin or fixed) with transfer counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_rr_dispatcher_x4
    import demux_pkg::*;
#(
    parameter int BUS_WIDTH = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BUS_WIDTH-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 mode,
    input  logic [1:0]           fix_sel,
    input  logic [3:0]           ch_en,
    output logic [BUS_WIDTH-1:0] out_data,
    output logic [3:0]           out_valid,
    input  logic [3:0]           out_ready,
    output logic [1:0]           cur_sel,
    input  logic                 cnt_clr,
    output logic [CNT_WIDTH-1:0] cnt0,
    output logic [CNT_WIDTH-1:0] cnt1,
    output logic [CNT_WIDTH-1:0] cnt2,
    output logic [CNT_WIDTH-1:0] cnt3
);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [1:0]             r_ptr;
    logic [BUS_WIDTH-1:0]   r_data;
    logic [3:0]             r_valid;
    logic [1:0]             r_sel;
    logic [CNT_WIDTH-1:0]   r_cnt [NUM_CH];

    logic [3:0]             w_req;
    logic [1:0]             w_tgt;
    logic                   w_found;
    logic                   w_fire;
    logic                   w_accept;

    // Fixed mode reuses the picker with a single-bit mask.
    assign w_req = (mode == MODE_FIXED) ? ((4'b0001 << fix_sel) & ch_en) : ch_en;

    rr_pick4 u_pick (
        .req   (w_req),
        .start (r_ptr),
        .idx   (w_tgt),
        .found (w_found)
    );

    assign w_fire   = (r_state == FULL) && out_ready[r_sel];
    assign in_ready = ((r_state == EMPTY) || w_fire) && w_found;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY:   if (w_accept) w_state_nxt = FULL;
            FULL:    if (w_fire && !w_accept) w_state_nxt = EMPTY;
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= 2'd0;
            r_data  <= '0;
            r_valid <= 4'b0000;
            r_sel   <= 2'd0;
        end else if (w_accept) begin
            r_data  <= in_data;
            r_sel   <= w_tgt;
            r_valid <= 4'b0001 << w_tgt;
            if (mode == MODE_RR) begin
                r_ptr <= w_tgt + 2'd1;
            end
        end else if (w_fire) begin
            r_valid <= 4'b0000;
        end
    end

    // Clear takes priority over a same-cycle fire; counts saturate at all-ones.
    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt[g] <= '0;
                end else if (cnt_clr) begin
                    r_cnt[g] <= '0;
                end else if (w_fire && (r_sel == 2'(g)) && (r_cnt[g] != '1)) begin
                    r_cnt[g] <= r_cnt[g] + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                end
            end
        end
    endgenerate

    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign cur_sel   = r_sel;
    assign cnt0      = r_cnt[0];
    assign cnt1      = r_cnt[1];
    assign cnt2      = r_cnt[2];
    assign cnt3      = r_cnt[3];

endmodule

`default_nettype wire
